lpf_frame_sequencer: RTL and testbench
======================================

Name: lpf_frame_sequencer

Overview:
Frame-synchronous controller for the vocal-effect one-pole low-pass stage, y = x + ((y_prev - x)·α) >>> 8, per channel. On each DAC left/right frame start it captures the stereo sample and time-shares one signed multiplier between left and right over fixed BCLK cycles. It also owns the coefficient register: a configuration handshake that applies only at frame boundaries, plus bypass, enable and overrun status. It sits between the codec ADC deserializer and the DAC serializer.

Parameters:
DATA_W, 16, per-channel sample width (two's complement)
COEF_W, 8, feedback coefficient width, unsigned Q0.8 (α/256)
ALPHA_RESET, 230, active/pending coefficient after reset (≈0.9)

Ports:
AUD_BCLK  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low
AUD_DACLRCK  in  1  DAC frame clock; a 0→1 transition starts a frame
enable  in  1  1 = process frames; 0 = ignore frame starts
bypass  in  1  1 = output = captured input
datain  in  2*DATA_W  {left[31:16], right[15:0]}
cfg_wr  in  1  single-cycle coefficient write strobe
cfg_alpha  in  COEF_W  coefficient written on cfg_wr
overrun_clr  in  1  clears overrun
dataout  out  2*DATA_W  filtered {left, right}, held between frames
out_valid  out  1  one-cycle pulse when dataout updates
busy  out  1  FSM not IDLE
cfg_ack  out  1  one-cycle pulse the cycle after cfg_wr
overrun  out  1  sticky: frame start arrived while busy

Behaviour:
- Reset (async, reset=0): dataout=0, y_prev L/R=0, out_valid=0, busy=0, cfg_ack=0, overrun=0, FSM=IDLE, alpha_pending=alpha_active=ALPHA_RESET.
- Frame start: lrck_d registers AUD_DACLRCK; start = AUD_DACLRCK & ~lrck_d & enable, evaluated in cycle N.
- FSM IDLE→LOAD→CALC_L→CALC_R→COMMIT→IDLE, one cycle per state.
  - IDLE: on start, go to LOAD.
  - LOAD (N+1): capture datain into x_L/x_R; copy alpha_pending into alpha_active.
  - CALC_L (N+2): shared multiplier computes d=(y_prev_L − x_L) as DATA_W+1 bits × {1'b0,alpha_active}; r_L = x_L + (product >>> 8), arithmetic floor.
  - CALC_R (N+3): same for right.
  - COMMIT (N+4): dataout and y_prev take r_L/r_R (or x_L/x_R when bypass=1); out_valid=1 for this cycle.
- Latency: 4 cycles from the start cycle to the out_valid cycle. Frame start to frame start must be ≥5 cycles.
- Width rules:
  - Product is DATA_W+COEF_W+2 bits.
  - Result is formed at DATA_W+2 bits, then saturated to [−32768, 32767].
  - Saturation is unreachable for α≤255 but is mandatory.
- α=0 gives y=x; α=255 gives maximum smoothing.
- busy=1 in every state except IDLE.
- Start while busy: the edge is ignored, the frame in flight completes unchanged, and overrun is set. overrun_clr clears it; set wins if both occur in the same cycle.
- enable=0: start is suppressed, no overrun is raised, dataout holds. Deasserting enable mid-frame does not abort the frame in flight.
- Config handshake:
  - cfg_wr loads alpha_pending; cfg_ack pulses next cycle.
  - Back-to-back writes: last value wins, one ack per write.
  - cfg_wr in the same cycle as LOAD: LOAD uses the old alpha_pending; the new value applies from the next frame.
- Bypass is sampled in COMMIT. Bypass still updates y_prev, so un-bypassing has no step transient.
- Reset asserted mid-frame: immediate return to reset state; a partial frame never produces out_valid.

Decomposition:
- Package lpf_seq_pkg holds:
  - DATA_W and COEF_W defaults
  - state enum (IDLE, LOAD, CALC_L, CALC_R, COMMIT)
  - sat16 function (DATA_W+2 → DATA_W)
- Sub-module lpf_mac: combinational x + ((y−x)·α >>> 8) with saturation, instanced once and muxed between channels by the FSM.

Test Plan:
- Reset, then α=128 written (cfg_ack next cycle), then frame with L=1000, R=−1000 → out_valid 4 cycles after start; dataout L=500, R=−500. Next frame with the same input → L=750, R=−750.
- α=0 via cfg_wr, frame L=0x1234, R=0x8000 → dataout=0x12348000. α=255 with y_prev=0, x=256 → 1.
- cfg_wr(α=64) in the LOAD cycle of a frame run at α=128 → that frame uses 128; the next frame uses 64.
- Second DACLRCK rise 2 cycles after the first → one out_valid only, overrun=1; overrun_clr → 0. enable=0 with edges → no busy, no out_valid, no overrun.
- bypass=1, x=−300 → dataout=−300. Then bypass=0, α=128, x=−300 → −300 (no step).
- reset pulsed during CALC_R → all outputs 0 immediately, no out_valid. The next normal frame starts from y_prev=0 and α=ALPHA_RESET.

Source files
------------

// File: rtl/lpf_seq_pkg.sv
// Shared widths, FSM state encoding and output saturation for the low-pass frame sequencer.
package lpf_seq_pkg;

  localparam int LPF_DATA_W = 16;
  localparam int LPF_COEF_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC_L = 3'd2,
    ST_CALC_R = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Clamp a DATA_W+2 bit result into the signed DATA_W range.
  function automatic logic [LPF_DATA_W-1:0] sat16(input logic [LPF_DATA_W+1:0] v);
    if (v[LPF_DATA_W+1:LPF_DATA_W-1] == {3{v[LPF_DATA_W+1]}}) begin
      return v[LPF_DATA_W-1:0];
    end
    return v[LPF_DATA_W+1] ? {1'b1, {(LPF_DATA_W-1){1'b0}}} : {1'b0, {(LPF_DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/lpf_mac.sv
// One-pole step r = x + ((y_prev - x) * alpha) >>> COEF_W, saturated; shared by both channels.
module lpf_mac
  import lpf_seq_pkg::*;
#(
  parameter int DATA_W = LPF_DATA_W,
  parameter int COEF_W = LPF_COEF_W
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y_prev,
  input  logic        [COEF_W-1:0] alpha,
  output logic signed [DATA_W-1:0] r
);

  localparam int PROD_W = DATA_W + COEF_W + 2;

  logic [DATA_W:0]   diff;
  logic [PROD_W-1:0] prod;
  logic [DATA_W+1:0] sum;
  logic              unused_prod_lsb;

  // Low PROD_W bits of a sign-extended by zero-extended product equal the signed product.
  always_comb begin
    diff = {y_prev[DATA_W-1], y_prev} - {x[DATA_W-1], x};
    prod = {{(COEF_W+1){diff[DATA_W]}}, diff} * {{(DATA_W+2){1'b0}}, alpha};
    sum  = {{2{x[DATA_W-1]}}, x} + prod[PROD_W-1:COEF_W];
    r    = sat16(sum);
  end

  assign unused_prod_lsb = ^prod[COEF_W-1:0];

endmodule

// File: rtl/lpf_frame_sequencer.sv
// Frame-synchronous stereo one-pole low-pass controller with frame-aligned coefficient updates.
// state     | meaning
// ST_IDLE   | waiting for an enabled DACLRCK rising edge
// ST_LOAD   | capture datain, latch pending alpha as active
// ST_CALC_L | shared MAC computes left result
// ST_CALC_R | shared MAC computes right result
// ST_COMMIT | drive dataout / update y_prev, out_valid high
module lpf_frame_sequencer
  import lpf_seq_pkg::*;
#(
  parameter int          DATA_W      = LPF_DATA_W,
  parameter int          COEF_W      = LPF_COEF_W,
  parameter int unsigned ALPHA_RESET = 230
) (
  input  logic                AUD_BCLK,
  input  logic                reset,
  input  logic                AUD_DACLRCK,
  input  logic                enable,
  input  logic                bypass,
  input  logic [2*DATA_W-1:0] datain,
  input  logic                cfg_wr,
  input  logic [COEF_W-1:0]   cfg_alpha,
  input  logic                overrun_clr,
  output logic [2*DATA_W-1:0] dataout,
  output logic                out_valid,
  output logic                busy,
  output logic                cfg_ack,
  output logic                overrun
);

  state_e state_q, state_d;
  logic   lrck_q, lrck_d;
  logic   frame_edge, start, sel_r, commit;

  logic signed [DATA_W-1:0] x_l_q, x_l_d, x_r_q, x_r_d;
  logic signed [DATA_W-1:0] y_l_q, y_l_d, y_r_q, y_r_d;
  logic signed [DATA_W-1:0] r_l_q, r_l_d, r_r_q, r_r_d;
  logic signed [DATA_W-1:0] mac_x, mac_y, mac_r;
  logic [COEF_W-1:0]        alpha_pending_q, alpha_pending_d;
  logic [COEF_W-1:0]        alpha_active_q, alpha_active_d;
  logic [2*DATA_W-1:0]      dataout_q, dataout_d, commit_val;
  logic                     cfg_ack_q, cfg_ack_d, overrun_q, overrun_d;

  assign frame_edge = AUD_DACLRCK & ~lrck_q;
  assign start      = frame_edge & enable;

  always_ff @(posedge AUD_BCLK or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_CALC_L;
      ST_CALC_L: state_d = ST_CALC_R;
      ST_CALC_R: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    commit    = (state_q == ST_COMMIT);
    out_valid = commit;
    sel_r     = (state_q == ST_CALC_R);
  end

  assign mac_x = sel_r ? x_r_q : x_l_q;
  assign mac_y = sel_r ? y_r_q : y_l_q;

  lpf_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac (
    .x      (mac_x),
    .y_prev (mac_y),
    .alpha  (alpha_active_q),
    .r      (mac_r)
  );

  // Bypass is looked at only in COMMIT; y_prev follows the output either way.
  assign commit_val = bypass ? {x_l_q, x_r_q} : {r_l_q, r_r_q};
  assign dataout    = commit ? commit_val : dataout_q;
  assign cfg_ack    = cfg_ack_q;
  assign overrun    = overrun_q;

  always_comb begin
    lrck_d          = AUD_DACLRCK;
    x_l_d           = x_l_q;
    x_r_d           = x_r_q;
    y_l_d           = y_l_q;
    y_r_d           = y_r_q;
    r_l_d           = r_l_q;
    r_r_d           = r_r_q;
    dataout_d       = dataout_q;
    alpha_active_d  = alpha_active_q;
    alpha_pending_d = cfg_wr ? cfg_alpha : alpha_pending_q;
    cfg_ack_d       = cfg_wr;
    overrun_d       = (frame_edge & enable & busy) | (overrun_q & ~overrun_clr);
    case (state_q)
      ST_LOAD: begin
        x_l_d          = datain[2*DATA_W-1:DATA_W];
        x_r_d          = datain[DATA_W-1:0];
        alpha_active_d = alpha_pending_q;
      end
      ST_CALC_L: r_l_d = mac_r;
      ST_CALC_R: r_r_d = mac_r;
      ST_COMMIT: begin
        dataout_d = commit_val;
        y_l_d     = commit_val[2*DATA_W-1:DATA_W];
        y_r_d     = commit_val[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge AUD_BCLK or negedge reset) begin
    if (!reset) begin
      lrck_q          <= 1'b0;
      x_l_q           <= '0;
      x_r_q           <= '0;
      y_l_q           <= '0;
      y_r_q           <= '0;
      r_l_q           <= '0;
      r_r_q           <= '0;
      dataout_q       <= '0;
      alpha_pending_q <= COEF_W'(ALPHA_RESET);
      alpha_active_q  <= COEF_W'(ALPHA_RESET);
      cfg_ack_q       <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      lrck_q          <= lrck_d;
      x_l_q           <= x_l_d;
      x_r_q           <= x_r_d;
      y_l_q           <= y_l_d;
      y_r_q           <= y_r_d;
      r_l_q           <= r_l_d;
      r_r_q           <= r_r_d;
      dataout_q       <= dataout_d;
      alpha_pending_q <= alpha_pending_d;
      alpha_active_q  <= alpha_active_d;
      cfg_ack_q       <= cfg_ack_d;
      overrun_q       <= overrun_d;
    end
  end

endmodule

// File: tb/tb_lpf_frame_sequencer.sv
// Self-checking bench: directed plan scenarios plus randomized frames against an arithmetic filter model.
module tb_lpf_frame_sequencer;

  logic        AUD_BCLK = 1'b0;
  logic        reset = 1'b0;
  logic        AUD_DACLRCK = 1'b0;
  logic        enable = 1'b1;
  logic        bypass = 1'b0;
  logic [31:0] datain = '0;
  logic        cfg_wr = 1'b0;
  logic [7:0]  cfg_alpha = '0;
  logic        overrun_clr = 1'b0;
  logic [31:0] dataout;
  logic        out_valid, busy, cfg_ack, overrun;

  int checks = 0;
  int failures = 0;
  int m_yl = 0, m_yr = 0, m_pend = 230, m_act = 230;

  lpf_frame_sequencer dut (
    .AUD_BCLK    (AUD_BCLK),
    .reset       (reset),
    .AUD_DACLRCK (AUD_DACLRCK),
    .enable      (enable),
    .bypass      (bypass),
    .datain      (datain),
    .cfg_wr      (cfg_wr),
    .cfg_alpha   (cfg_alpha),
    .overrun_clr (overrun_clr),
    .dataout     (dataout),
    .out_valid   (out_valid),
    .busy        (busy),
    .cfg_ack     (cfg_ack),
    .overrun     (overrun)
  );

  always #5 AUD_BCLK = ~AUD_BCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // y = x + floor((y_prev - x) * a / 256), clamped to 16-bit signed
  function automatic int filt(input int x, input int y, input int a);
    int p, r;
    p = ((y - x) * a) >>> 8;
    r = x + p;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic logic [31:0] pack(input int l, input int r);
    return {l[15:0], r[15:0]};
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick();
    @(posedge AUD_BCLK);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a);
    cfg_wr = 1'b1;
    cfg_alpha = a;
    m_pend = int'(a);
    tick();
    cfg_wr = 1'b0;
    chk("cfg_ack_pulse", {31'd0, cfg_ack}, 32'd1);
    tick();
    chk("cfg_ack_drop", {31'd0, cfg_ack}, 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input logic byp,
                           input bit wr_in_load, input logic [7:0] wa, input string tag);
    int lat, el, er;
    logic [31:0] exp_out;
    AUD_DACLRCK = 1'b0;
    tick();
    datain = {l, r};
    bypass = byp;
    AUD_DACLRCK = 1'b1;
    m_act = m_pend;
    el = byp ? s16(l) : filt(s16(l), m_yl, m_act);
    er = byp ? s16(r) : filt(s16(r), m_yr, m_act);
    m_yl = el;
    m_yr = er;
    exp_out = pack(el, er);
    tick();
    lat = 1;
    chk({tag, "_busy_load"}, {31'd0, busy}, 32'd1);
    if (wr_in_load) begin
      cfg_wr = 1'b1;
      cfg_alpha = wa;
      m_pend = int'(wa);
    end
    while (!out_valid && lat < 8) begin
      tick();
      cfg_wr = 1'b0;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_data"}, dataout, exp_out);
    chk({tag, "_busy_commit"}, {31'd0, busy}, 32'd1);
    AUD_DACLRCK = 1'b0;
    tick();
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hold"}, dataout, exp_out);
  endtask

  initial begin
    int cnt;
    logic [31:0] seen, exp_out;
    tick();
    tick();
    chk("rst_dataout", dataout, 32'd0);
    chk("rst_flags", {28'd0, out_valid, busy, cfg_ack, overrun}, 32'd0);
    reset = 1'b1;
    tick();

    cfg_write(8'd128);
    run_frame(16'd1000, 16'hFC18, 1'b0, 1'b0, 8'd0, "a128_f1");
    chk("plan_500", dataout, pack(500, -500));
    run_frame(16'd1000, 16'hFC18, 1'b0, 1'b0, 8'd0, "a128_f2");
    chk("plan_750", dataout, pack(750, -750));

    cfg_write(8'd0);
    run_frame(16'h1234, 16'h8000, 1'b0, 1'b0, 8'd0, "a0");
    chk("plan_a0", dataout, 32'h12348000);
    run_frame(16'd0, 16'd0, 1'b0, 1'b0, 8'd0, "a0_zero");
    cfg_write(8'd255);
    run_frame(16'd256, 16'd256, 1'b0, 1'b0, 8'd0, "a255");
    chk("plan_a255", dataout, pack(1, 1));

    cfg_write(8'd128);
    run_frame(16'd2000, 16'd0, 1'b0, 1'b1, 8'd64, "load_wr");
    chk("plan_load_old", dataout, pack(1000, 0));
    run_frame(16'd2000, 16'd0, 1'b0, 1'b0, 8'd0, "load_next");
    chk("plan_load_new", dataout, pack(1750, 0));

    // second rising edge two cycles into a frame
    AUD_DACLRCK = 1'b0;
    tick();
    datain = {16'd4000, 16'hF060};
    AUD_DACLRCK = 1'b1;
    m_act = m_pend;
    m_yl = filt(4000, m_yl, m_act);
    m_yr = filt(-4000, m_yr, m_act);
    exp_out = pack(m_yl, m_yr);
    tick();
    AUD_DACLRCK = 1'b0;
    tick();
    AUD_DACLRCK = 1'b1;
    cnt = 0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        cnt++;
        seen = dataout;
      end
    end
    chk("ovr_valid_count", cnt, 32'd1);
    chk("ovr_data", seen, exp_out);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    AUD_DACLRCK = 1'b0;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);

    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      AUD_DACLRCK = ~AUD_DACLRCK;
      tick();
      if (busy || out_valid || overrun) cnt++;
    end
    chk("dis_activity", cnt, 32'd0);
    chk("dis_hold", dataout, exp_out);
    enable = 1'b1;
    AUD_DACLRCK = 1'b0;
    tick();

    run_frame(16'hFED4, 16'hFED4, 1'b1, 1'b0, 8'd0, "byp_on");
    chk("plan_byp", dataout, pack(-300, -300));
    cfg_write(8'd128);
    run_frame(16'hFED4, 16'hFED4, 1'b0, 1'b0, 8'd0, "byp_off");
    chk("plan_nostep", dataout, pack(-300, -300));

    // reset asserted while the FSM sits in CALC_R
    AUD_DACLRCK = 1'b0;
    tick();
    datain = {16'd9000, 16'd9000};
    AUD_DACLRCK = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_dataout", dataout, 32'd0);
    chk("mid_rst_flags", {28'd0, out_valid, busy, cfg_ack, overrun}, 32'd0);
    AUD_DACLRCK = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("mid_no_valid", cnt, 32'd0);
    reset = 1'b1;
    m_yl = 0;
    m_yr = 0;
    m_pend = 230;
    m_act = 230;
    run_frame(16'd1000, 16'd1000, 1'b0, 1'b0, 8'd0, "post_rst");
    chk("plan_post_rst", dataout, pack(101, 101));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(8'($urandom_range(0, 255)));
      run_frame(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)), "rnd");
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
